// File: rtl/bsg_cgol_row.sv
// bsg_cgol_row: one row of Life-like cells with a runtime rule (birth/survive masks).
// Keeps a generation counter, a registered popcount and a changed flag.
// Optional per-cell age counters are enabled by defining BSG_CGOL_ROW_AGE_EN.
module bsg_cgol_row #(
  parameter int width_p     = 8,
  parameter int wrap_p      = 0,
  parameter int gen_width_p = 16,
  parameter int age_width_p = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          en_i,
  input  logic [8:0]                    birth_mask_i,
  input  logic [8:0]                    survive_mask_i,
  input  logic [width_p-1:0]            north_i,
  input  logic [width_p-1:0]            south_i,
  input  logic                          update_i,
  input  logic [width_p-1:0]            update_val_i,
  output logic [width_p-1:0]            data_o,
  output logic [$clog2(width_p+1)-1:0]  alive_cnt_o,
  output logic [gen_width_p-1:0]        gen_o,
  output logic                          changed_o
`ifdef BSG_CGOL_ROW_AGE_EN
  ,
  output logic [width_p*age_width_p-1:0] age_o
`endif
);

  localparam int cnt_width_lp = $clog2(width_p+1);

  logic [width_p-1:0]      data_reg;
  logic [width_p-1:0]      data_next;
  logic [width_p-1:0]      step_next;
  logic [cnt_width_lp-1:0] cnt_reg;
  logic [cnt_width_lp-1:0] cnt_next;
  logic [gen_width_p-1:0]  gen_reg;
  logic                    changed_reg;

  // Left/right neighbour taps for the three rows; edges either wrap or read dead.
  logic [width_p-1:0] n_l, n_r, s_l, s_r, r_l, r_r;
  logic [3:0]         sum [width_p];

  genvar gi;
  generate
    for (gi = 0; gi < width_p; gi++) begin : g_cell
      if (gi == 0) begin : g_left_edge
        assign n_l[gi] = (wrap_p != 0) ? north_i[width_p-1]  : 1'b0;
        assign s_l[gi] = (wrap_p != 0) ? south_i[width_p-1]  : 1'b0;
        assign r_l[gi] = (wrap_p != 0) ? data_reg[width_p-1] : 1'b0;
      end else begin : g_left
        assign n_l[gi] = north_i[gi-1];
        assign s_l[gi] = south_i[gi-1];
        assign r_l[gi] = data_reg[gi-1];
      end

      if (gi == width_p-1) begin : g_right_edge
        assign n_r[gi] = (wrap_p != 0) ? north_i[0]  : 1'b0;
        assign s_r[gi] = (wrap_p != 0) ? south_i[0]  : 1'b0;
        assign r_r[gi] = (wrap_p != 0) ? data_reg[0] : 1'b0;
      end else begin : g_right
        assign n_r[gi] = north_i[gi+1];
        assign s_r[gi] = south_i[gi+1];
        assign r_r[gi] = data_reg[gi+1];
      end

      assign sum[gi] = {3'b0, n_l[gi]} + {3'b0, north_i[gi]} + {3'b0, n_r[gi]}
                     + {3'b0, s_l[gi]} + {3'b0, south_i[gi]} + {3'b0, s_r[gi]}
                     + {3'b0, r_l[gi]} + {3'b0, r_r[gi]};

      // Live cells consult the survive rule, dead cells the birth rule.
      assign step_next[gi] = data_reg[gi] ? survive_mask_i[sum[gi]] : birth_mask_i[sum[gi]];
    end
  endgenerate

  // Next row value (load beats step) and its popcount, so the count tracks data_o exactly.
  always_comb begin
    data_next = data_reg;
    if (update_i)  data_next = update_val_i;
    else if (en_i) data_next = step_next;
    cnt_next = '0;
    for (int i = 0; i < width_p; i++) begin
      cnt_next = cnt_next + cnt_width_lp'(data_next[i]);
    end
  end

  // Row state, generation counter, popcount and changed flag; idle cycles hold everything.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_reg    <= '0;
      cnt_reg     <= '0;
      gen_reg     <= '0;
      changed_reg <= 1'b0;
    end else if (update_i || en_i) begin
      data_reg    <= data_next;
      cnt_reg     <= cnt_next;
      gen_reg     <= update_i ? '0 : gen_reg + gen_width_p'(1);
      changed_reg <= |(data_next ^ data_reg);
    end
  end

  assign data_o      = data_reg;
  assign alive_cnt_o = cnt_reg;
  assign gen_o       = gen_reg;
  assign changed_o   = changed_reg;

`ifdef BSG_CGOL_ROW_AGE_EN
  logic [age_width_p-1:0] age_reg [width_p];

  generate
    for (gi = 0; gi < width_p; gi++) begin : g_age
      // Age counts consecutive survivals (saturating); any other outcome or a load clears it.
      always_ff @(posedge clk_i) begin
        if (reset_i || update_i) begin
          age_reg[gi] <= '0;
        end else if (en_i) begin
          if (data_reg[gi] && step_next[gi]) begin
            if (age_reg[gi] != {age_width_p{1'b1}}) age_reg[gi] <= age_reg[gi] + age_width_p'(1);
          end else begin
            age_reg[gi] <= '0;
          end
        end
      end
      assign age_o[gi*age_width_p +: age_width_p] = age_reg[gi];
    end
  endgenerate
`endif

endmodule

// File: tb/tb_bsg_cgol_row.sv
// Directed bench for bsg_cgol_row: several parameterisations share the control inputs.
module tb_bsg_cgol_row;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       en_i = 1'b0;
  logic       update_i = 1'b0;
  logic [8:0] birth_mask_i = 9'h008;
  logic [8:0] survive_mask_i = 9'h00C;
  logic [4:0] zero5 = 5'b0;
  logic [4:0] uval5 = 5'b0;
  logic [7:0] north8 = 8'h00;
  logic [7:0] south8 = 8'h00;
  logic [7:0] uval8 = 8'h00;

  logic [4:0] d5_data;  logic [2:0] d5_cnt;  logic [15:0] d5_gen;  logic d5_chg;
  logic [7:0] dw_data;  logic [3:0] dw_cnt;  logic [15:0] dw_gen;  logic dw_chg;
  logic [7:0] dn_data;  logic [3:0] dn_cnt;  logic [15:0] dn_gen;  logic dn_chg;
  logic [7:0] dg_data;  logic [3:0] dg_cnt;  logic [1:0]  dg_gen;  logic dg_chg;
`ifdef BSG_CGOL_ROW_AGE_EN
  logic [9:0]  d5_age;
  logic [31:0] dw_age;
  logic [31:0] dn_age;
  logic [15:0] dg_age;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bsg_cgol_row #(.width_p(5), .wrap_p(0)) u_d5 (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .birth_mask_i(birth_mask_i),
    .survive_mask_i(survive_mask_i), .north_i(zero5), .south_i(zero5),
    .update_i(update_i), .update_val_i(uval5), .data_o(d5_data),
    .alive_cnt_o(d5_cnt), .gen_o(d5_gen), .changed_o(d5_chg)
`ifdef BSG_CGOL_ROW_AGE_EN
    , .age_o(d5_age)
`endif
  );

  bsg_cgol_row #(.width_p(8), .wrap_p(1)) u_dw (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .birth_mask_i(birth_mask_i),
    .survive_mask_i(survive_mask_i), .north_i(north8), .south_i(south8),
    .update_i(update_i), .update_val_i(uval8), .data_o(dw_data),
    .alive_cnt_o(dw_cnt), .gen_o(dw_gen), .changed_o(dw_chg)
`ifdef BSG_CGOL_ROW_AGE_EN
    , .age_o(dw_age)
`endif
  );

  bsg_cgol_row #(.width_p(8), .wrap_p(0)) u_dn (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .birth_mask_i(birth_mask_i),
    .survive_mask_i(survive_mask_i), .north_i(north8), .south_i(south8),
    .update_i(update_i), .update_val_i(uval8), .data_o(dn_data),
    .alive_cnt_o(dn_cnt), .gen_o(dn_gen), .changed_o(dn_chg)
`ifdef BSG_CGOL_ROW_AGE_EN
    , .age_o(dn_age)
`endif
  );

  bsg_cgol_row #(.width_p(8), .wrap_p(0), .gen_width_p(2), .age_width_p(2)) u_dg (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .birth_mask_i(birth_mask_i),
    .survive_mask_i(survive_mask_i), .north_i(north8), .south_i(south8),
    .update_i(update_i), .update_val_i(uval8), .data_o(dg_data),
    .alive_cnt_o(dg_cnt), .gen_o(dg_gen), .changed_o(dg_chg)
`ifdef BSG_CGOL_ROW_AGE_EN
    , .age_o(dg_age)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs already driven, sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    tick();
    chk("rst_d5_data", 32'(d5_data), 32'h0);
    chk("rst_d5_cnt",  32'(d5_cnt),  32'h0);
    chk("rst_d5_gen",  32'(d5_gen),  32'h0);
    chk("rst_d5_chg",  32'(d5_chg),  32'h0);
    chk("rst_dg_data", 32'(dg_data), 32'h0);
    chk("rst_dg_gen",  32'(dg_gen),  32'h0);
    reset_i = 1'b0;

    // Load: d5 <- 01110, 8-bit rows <- 10000011
    update_i = 1'b1; uval5 = 5'b01110; uval8 = 8'b10000011;
    tick();
    chk("ld_d5_data", 32'(d5_data), 32'h0E);
    chk("ld_d5_cnt",  32'(d5_cnt),  32'h3);
    chk("ld_d5_chg",  32'(d5_chg),  32'h1);
    chk("ld_dw_cnt",  32'(dw_cnt),  32'h3);
    chk("ld_dn_gen",  32'(dn_gen),  32'h0);

    // One B3/S23 step
    update_i = 1'b0; en_i = 1'b1;
    tick();
    en_i = 1'b0;
    chk("t1_data", 32'(d5_data), 32'h04);
    chk("t1_cnt",  32'(d5_cnt),  32'h1);
    chk("t1_gen",  32'(d5_gen),  32'h1);
    chk("t1_chg",  32'(d5_chg),  32'h1);
    chk("t2_wrap_data",   32'(dw_data), 32'h01);
    chk("t2_wrap_cnt",    32'(dw_cnt),  32'h1);
    chk("t2_nowrap_data", 32'(dn_data), 32'h00);
    chk("t2_nowrap_cnt",  32'(dn_cnt),  32'h0);

    // Load zero onto an already-empty row: changed must be 0, gen cleared
    update_i = 1'b1; uval8 = 8'h00;
    tick();
    update_i = 1'b0;
    chk("t3_ld_chg", 32'(dn_chg), 32'h0);
    chk("t3_ld_gen", 32'(dn_gen), 32'h0);

    // Birth from three north neighbours
    north8 = 8'b00111000; en_i = 1'b1;
    tick();
    en_i = 1'b0; north8 = 8'h00;
    chk("t3_data", 32'(dn_data), 32'h10);
    chk("t3_cnt",  32'(dn_cnt),  32'h1);
    chk("t3_gen",  32'(dn_gen),  32'h1);
    chk("t3_chg",  32'(dn_chg),  32'h1);

    // Load beats step
    update_i = 1'b1; en_i = 1'b1; uval8 = 8'hA5;
    tick();
    update_i = 1'b0; en_i = 1'b0;
    chk("t4_data", 32'(dn_data), 32'hA5);
    chk("t4_gen",  32'(dn_gen),  32'h0);
    chk("t4_cnt",  32'(dn_cnt),  32'h4);
    chk("t4_chg",  32'(dn_chg),  32'h1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_idle_data", 32'(dn_data), 32'hA5);
      chk("t4_idle_gen",  32'(dn_gen),  32'h0);
      chk("t4_idle_cnt",  32'(dn_cnt),  32'h4);
      chk("t4_idle_chg",  32'(dn_chg),  32'h1);
    end

    // Stable block (row 00011000 with identical north row), 2-bit gen wrap
    update_i = 1'b1; uval8 = 8'h18;
    tick();
    update_i = 1'b0; north8 = 8'h18; en_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("t5_gen",  32'(dg_gen),  32'(k % 4));
      chk("t5_chg",  32'(dg_chg),  32'h0);
      chk("t5_data", 32'(dg_data), 32'h18);
    end
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0; en_i = 1'b0; north8 = 8'h00;
    chk("t5_rst_data", 32'(dg_data), 32'h0);
    chk("t5_rst_cnt",  32'(dg_cnt),  32'h0);
    chk("t5_rst_gen",  32'(dg_gen),  32'h0);
    chk("t5_rst_chg",  32'(dg_chg),  32'h0);
    chk("t5_rst_dn",   32'(dn_data), 32'h0);

`ifdef BSG_CGOL_ROW_AGE_EN
    // Age saturation on a cell kept alive by survive-all, then death clears age
    birth_mask_i = 9'h000; survive_mask_i = 9'h1FF;
    update_i = 1'b1; uval8 = 8'h01;
    tick();
    update_i = 1'b0;
    chk("t6_ld_age", 32'(dg_age[1:0]), 32'h0);
    en_i = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("t6_age", 32'(dg_age[1:0]), 32'((k > 3) ? 3 : k));
    end
    survive_mask_i = 9'h000;
    tick();
    en_i = 1'b0;
    chk("t6_dead_data", 32'(dg_data), 32'h0);
    chk("t6_dead_age",  32'(dg_age[1:0]), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
